// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file.
// NREGS 32-bit registers behind independent one-entry AW, W and AR holding
// buffers. AW and W may arrive in either order; a write fires once both are
// present and the B channel can take a response. Reads fire once an address
// is present and the R channel is free. Out-of-range word indices answer
// SLVERR and leave the registers untouched. All ready/valid outputs come
// straight from flops, so there is no input-to-handshake combinational path.
module axil_regfile #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int NREGS            = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,

  input  logic                          i_axi_awvalid,
  output logic                          o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
  input  logic [2:0]                    i_axi_awprot,

  input  logic                          i_axi_wvalid,
  output logic                          o_axi_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,

  output logic                          o_axi_bvalid,
  input  logic                          i_axi_bready,
  output logic [1:0]                    o_axi_bresp,

  input  logic                          i_axi_arvalid,
  output logic                          o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
  input  logic [2:0]                    i_axi_arprot,

  output logic                          o_axi_rvalid,
  input  logic                          i_axi_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata,
  output logic [1:0]                    o_axi_rresp
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = AW - 2;
  // Width of the physical register index; at least one bit.
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [IW:0] NREGS_W = (IW+1)'(NREGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register storage
  logic [DW-1:0] regs_q [NREGS];

  // Write address holding buffer
  logic          aw_held_q, aw_held_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d;

  // Write data holding buffer
  logic          w_held_q, w_held_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;

  // Write response channel
  logic          b_valid_q, b_valid_d;
  logic [1:0]    b_resp_q, b_resp_d;

  // Read address holding buffer
  logic          ar_held_q, ar_held_d;
  logic [AW-1:0] ar_addr_q, ar_addr_d;

  // Read response channel
  logic          r_valid_q, r_valid_d;
  logic [DW-1:0] r_data_q, r_data_d;
  logic [1:0]    r_resp_q, r_resp_d;

  // Handshake and fire qualifiers
  logic          aw_hs, w_hs, ar_hs;
  logic          b_free, r_free;
  logic          wr_fire, rd_fire;

  // Effective write/read operands (held entry wins; it is always the older one)
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [RW-1:0] wr_slot, rd_slot;
  logic          wr_in_range, rd_in_range;
  logic [DW-1:0] rd_word;

  // Readies are the inverse of the holding flags, so they are registered.
  assign o_axi_awready = !aw_held_q;
  assign o_axi_wready  = !w_held_q;
  assign o_axi_arready = !ar_held_q;

  assign o_axi_bvalid  = b_valid_q;
  assign o_axi_bresp   = b_resp_q;
  assign o_axi_rvalid  = r_valid_q;
  assign o_axi_rdata   = r_data_q;
  assign o_axi_rresp   = r_resp_q;

  assign aw_hs   = i_axi_awvalid && !aw_held_q;
  assign w_hs    = i_axi_wvalid  && !w_held_q;
  assign ar_hs   = i_axi_arvalid && !ar_held_q;

  assign b_free  = !b_valid_q || i_axi_bready;
  assign r_free  = !r_valid_q || i_axi_rready;

  assign wr_fire = (aw_held_q || aw_hs) && (w_held_q || w_hs) && b_free;
  assign rd_fire = (ar_held_q || ar_hs) && r_free;

  assign wr_addr = aw_held_q ? aw_addr_q : i_axi_awaddr;
  assign wr_data = w_held_q  ? w_data_q  : i_axi_wdata;
  assign wr_strb = w_held_q  ? w_strb_q  : i_axi_wstrb;
  assign rd_addr = ar_held_q ? ar_addr_q : i_axi_araddr;

  assign wr_idx      = wr_addr[AW-1:2];
  assign rd_idx      = rd_addr[AW-1:2];
  assign wr_in_range = {1'b0, wr_idx} < NREGS_W;
  assign rd_in_range = {1'b0, rd_idx} < NREGS_W;
  assign wr_slot     = wr_idx[RW-1:0];
  assign rd_slot     = rd_idx[RW-1:0];

  // regs_q is the pre-write value, so a same-cycle read sees the old data.
  assign rd_word     = rd_in_range ? regs_q[rd_slot] : '0;

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{i_axi_awprot, i_axi_arprot, wr_addr[1:0], rd_addr[1:0]};

  // Write-side holding buffers and B response next state
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;

    if (wr_fire) begin
      aw_held_d = 1'b0;
    end else if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = i_axi_awaddr;
    end

    if (wr_fire) begin
      w_held_d = 1'b0;
    end else if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = i_axi_wdata;
      w_strb_d = i_axi_wstrb;
    end

    if (wr_fire) begin
      b_valid_d = 1'b1;
      b_resp_d  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (i_axi_bready) begin
      b_valid_d = 1'b0;
    end
  end

  // Read-side holding buffer and R response next state
  always_comb begin
    ar_held_d = ar_held_q;
    ar_addr_d = ar_addr_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;

    if (rd_fire) begin
      ar_held_d = 1'b0;
    end else if (ar_hs) begin
      ar_held_d = 1'b1;
      ar_addr_d = i_axi_araddr;
    end

    if (rd_fire) begin
      r_valid_d = 1'b1;
      r_data_d  = rd_word;
      r_resp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (i_axi_rready) begin
      r_valid_d = 1'b0;
    end
  end

  // Channel state registers; reset drops held entries and pending responses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      ar_held_q <= 1'b0;
      ar_addr_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      ar_held_q <= ar_held_d;
      ar_addr_q <= ar_addr_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // Register array update with byte strobes; out-of-range writes are dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire && wr_in_range) begin
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) begin
          regs_q[wr_slot][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Bench for axil_regfile: directed scenarios followed by randomized traffic.
// A negedge monitor keeps a transaction-level model (address/data queues and
// a word array) and checks every B and R response against it.
module tb_axil_regfile;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_axi_awvalid;
  logic        o_axi_awready;
  logic [7:0]  i_axi_awaddr;
  logic [2:0]  i_axi_awprot;
  logic        i_axi_wvalid;
  logic        o_axi_wready;
  logic [31:0] i_axi_wdata;
  logic [3:0]  i_axi_wstrb;
  logic        o_axi_bvalid;
  logic        i_axi_bready;
  logic [1:0]  o_axi_bresp;
  logic        i_axi_arvalid;
  logic        o_axi_arready;
  logic [7:0]  i_axi_araddr;
  logic [2:0]  i_axi_arprot;
  logic        o_axi_rvalid;
  logic        i_axi_rready;
  logic [31:0] o_axi_rdata;
  logic [1:0]  o_axi_rresp;

  axil_regfile #(
    .C_AXI_DATA_WIDTH(32),
    .C_AXI_ADDR_WIDTH(8),
    .NREGS(16)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_axi_awvalid(i_axi_awvalid),
    .o_axi_awready(o_axi_awready),
    .i_axi_awaddr(i_axi_awaddr),
    .i_axi_awprot(i_axi_awprot),
    .i_axi_wvalid(i_axi_wvalid),
    .o_axi_wready(o_axi_wready),
    .i_axi_wdata(i_axi_wdata),
    .i_axi_wstrb(i_axi_wstrb),
    .o_axi_bvalid(o_axi_bvalid),
    .i_axi_bready(i_axi_bready),
    .o_axi_bresp(o_axi_bresp),
    .i_axi_arvalid(i_axi_arvalid),
    .o_axi_arready(o_axi_arready),
    .i_axi_araddr(i_axi_araddr),
    .i_axi_arprot(i_axi_arprot),
    .o_axi_rvalid(o_axi_rvalid),
    .i_axi_rready(i_axi_rready),
    .o_axi_rdata(o_axi_rdata),
    .o_axi_rresp(o_axi_rresp)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one word per implemented register plus in-order
  // queues of accepted requests awaiting their responses.
  logic [31:0] mem [16];
  logic [7:0]  awq [$];
  logic [31:0] wdq [$];
  logic [3:0]  wsq [$];
  logic [7:0]  arq [$];

  logic        prev_bv, prev_bhs, prev_rv, prev_rhs;
  logic [1:0]  prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;
  logic [7:0]  m_a;
  logic [31:0] m_d;
  logic [3:0]  m_s;

  int aw_sent, w_sent;
  logic aw_go, w_go, ar_go;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [7:0] a);
    return a[7:2] < 6'd16;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [7:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [7:0] rand_addr();
    logic [5:0] idx;
    logic [1:0] lo;
    idx = 6'($urandom_range(0, 19));
    lo  = 2'($urandom_range(0, 3));
    return {idx, lo};
  endfunction

  // Monitor: at each negedge the outputs reflect the last posedge and the
  // inputs are what the next posedge will see.
  always @(negedge i_clk) begin
    if (i_reset) begin
      awq.delete(); wdq.delete(); wsq.delete(); arq.delete();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      prev_bv = 1'b0; prev_bhs = 1'b0; prev_rv = 1'b0; prev_rhs = 1'b0;
      prev_bresp = '0; prev_rresp = '0; prev_rdata = '0;
    end else begin
      // Reads are judged before same-cycle writes land: a read whose
      // response shows up together with a write's response fired together
      // with it and must see the old value.
      if (prev_rv && !prev_rhs) begin
        check("r_hold_valid", 32'(o_axi_rvalid), 32'(1));
        check("r_hold_data", o_axi_rdata, prev_rdata);
        check("r_hold_resp", 32'(o_axi_rresp), 32'(prev_rresp));
      end else if (o_axi_rvalid) begin
        check("r_unmatched", 32'(arq.size() == 0), 32'(0));
        if (arq.size() > 0) begin
          m_a = arq.pop_front();
          check("r_resp", 32'(o_axi_rresp), 32'(exp_resp(m_a)));
          check("r_data", o_axi_rdata, in_rng(m_a) ? mem[m_a[5:2]] : 32'h0);
        end
      end

      if (prev_bv && !prev_bhs) begin
        check("b_hold_valid", 32'(o_axi_bvalid), 32'(1));
        check("b_hold_resp", 32'(o_axi_bresp), 32'(prev_bresp));
      end else if (o_axi_bvalid) begin
        check("b_unmatched", 32'(awq.size() == 0 || wdq.size() == 0), 32'(0));
        if (awq.size() > 0 && wdq.size() > 0) begin
          m_a = awq.pop_front();
          m_d = wdq.pop_front();
          m_s = wsq.pop_front();
          check("b_resp", 32'(o_axi_bresp), 32'(exp_resp(m_a)));
          if (in_rng(m_a)) begin
            for (int b = 0; b < 4; b++)
              if (m_s[b]) mem[m_a[5:2]][8*b +: 8] = m_d[8*b +: 8];
          end
        end
      end

      prev_bv    = o_axi_bvalid;
      prev_bhs   = o_axi_bvalid && i_axi_bready;
      prev_bresp = o_axi_bresp;
      prev_rv    = o_axi_rvalid;
      prev_rhs   = o_axi_rvalid && i_axi_rready;
      prev_rresp = o_axi_rresp;
      prev_rdata = o_axi_rdata;

      if (i_axi_awvalid && o_axi_awready) awq.push_back(i_axi_awaddr);
      if (i_axi_wvalid && o_axi_wready) begin
        wdq.push_back(i_axi_wdata);
        wsq.push_back(i_axi_wstrb);
      end
      if (i_axi_arvalid && o_axi_arready) arq.push_back(i_axi_araddr);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_axi_awvalid = 1'b0;
    i_axi_wvalid  = 1'b0;
    i_axi_arvalid = 1'b0;
  endtask

  task automatic set_aw(input logic [7:0] a);
    i_axi_awvalid = 1'b1; i_axi_awaddr = a;
  endtask

  task automatic set_w(input logic [31:0] d, input logic [3:0] s);
    i_axi_wvalid = 1'b1; i_axi_wdata = d; i_axi_wstrb = s;
  endtask

  task automatic set_ar(input logic [7:0] a);
    i_axi_arvalid = 1'b1; i_axi_araddr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    idle();
    i_axi_awaddr = '0; i_axi_wdata = '0; i_axi_wstrb = '0; i_axi_araddr = '0;
    i_axi_awprot = '0; i_axi_arprot = '0;
    i_axi_bready = 1'b1; i_axi_rready = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_awready", 32'(o_axi_awready), 32'(1));
    check("rst_wready",  32'(o_axi_wready),  32'(1));
    check("rst_arready", 32'(o_axi_arready), 32'(1));
    check("rst_bvalid",  32'(o_axi_bvalid),  32'(0));
    check("rst_rvalid",  32'(o_axi_rvalid),  32'(0));
    check("rst_bresp",   32'(o_axi_bresp),   32'(0));
    check("rst_rresp",   32'(o_axi_rresp),   32'(0));
    check("rst_rdata",   o_axi_rdata,        32'h0);
    i_reset = 1'b0;
    tick();

    // AW and W together, then read back
    set_aw(8'h04); set_w(32'hDEADBEEF, 4'hF);
    tick();
    check("t1_bvalid", 32'(o_axi_bvalid), 32'(1));
    check("t1_bresp",  32'(o_axi_bresp),  32'(0));
    check("t1_awready", 32'(o_axi_awready), 32'(1));
    idle();
    set_ar(8'h04);
    tick();
    check("t1_bdone",  32'(o_axi_bvalid), 32'(0));
    check("t1_rvalid", 32'(o_axi_rvalid), 32'(1));
    check("t1_rdata",  o_axi_rdata, 32'hDEADBEEF);
    check("t1_rresp",  32'(o_axi_rresp), 32'(0));
    idle();
    tick();

    // W leads AW by three cycles, partial strobes
    set_w(32'h11223344, 4'h5);
    tick();
    idle();
    check("t2_wready1", 32'(o_axi_wready), 32'(0));
    check("t2_nob1", 32'(o_axi_bvalid), 32'(0));
    tick();
    check("t2_wready2", 32'(o_axi_wready), 32'(0));
    tick();
    check("t2_wready3", 32'(o_axi_wready), 32'(0));
    set_aw(8'h08);
    tick();
    check("t2_bvalid", 32'(o_axi_bvalid), 32'(1));
    check("t2_wready_back", 32'(o_axi_wready), 32'(1));
    idle();
    set_ar(8'h08);
    tick();
    check("t2_rdata", o_axi_rdata, 32'h00220044);
    idle();
    tick();

    // Out-of-range index 16
    set_aw(8'h40); set_w(32'hFFFFFFFF, 4'hF);
    tick();
    check("t3_bresp", 32'(o_axi_bresp), 32'(2));
    idle();
    set_ar(8'h40);
    tick();
    check("t3_rresp", 32'(o_axi_rresp), 32'(2));
    check("t3_rdata", o_axi_rdata, 32'h0);
    set_ar(8'h00);
    tick();
    check("t3_reg0", o_axi_rdata, 32'h0);
    set_ar(8'h04);
    tick();
    check("t3_reg1", o_axi_rdata, 32'hDEADBEEF);
    idle();
    tick();

    // B back-pressure with three writes
    i_axi_bready = 1'b0;
    set_aw(8'h10); set_w(32'hA0A0A0A0, 4'hF);
    tick();
    set_aw(8'h14); set_w(32'hB1B1B1B1, 4'hF);
    tick();
    set_aw(8'h18); set_w(32'hC2C2C2C2, 4'hF);
    for (int k = 0; k < 3; k++) begin
      check("t4_stall_bvalid", 32'(o_axi_bvalid), 32'(1));
      check("t4_stall_awready", 32'(o_axi_awready), 32'(0));
      check("t4_stall_wready", 32'(o_axi_wready), 32'(0));
      tick();
    end
    check("t4_stall_bresp", 32'(o_axi_bresp), 32'(0));
    i_axi_bready = 1'b1;
    tick();
    check("t4_drain1_bvalid", 32'(o_axi_bvalid), 32'(1));
    check("t4_drain1_awready", 32'(o_axi_awready), 32'(1));
    check("t4_drain1_wready", 32'(o_axi_wready), 32'(1));
    tick();
    check("t4_drain2_bvalid", 32'(o_axi_bvalid), 32'(1));
    idle();
    tick();
    check("t4_drain3_bvalid", 32'(o_axi_bvalid), 32'(0));
    set_ar(8'h10);
    tick();
    check("t4_rd10", o_axi_rdata, 32'hA0A0A0A0);
    set_ar(8'h14);
    tick();
    check("t4_rd14", o_axi_rdata, 32'hB1B1B1B1);
    set_ar(8'h18);
    tick();
    check("t4_rd18", o_axi_rdata, 32'hC2C2C2C2);
    idle();
    tick();

    // Same-cycle read and write of one register
    set_aw(8'h0C); set_w(32'h1, 4'hF);
    tick();
    idle();
    tick();
    set_aw(8'h0C); set_w(32'h2, 4'hF); set_ar(8'h0C);
    tick();
    check("t5_old", o_axi_rdata, 32'h1);
    idle();
    set_ar(8'h0C);
    tick();
    check("t5_new", o_axi_rdata, 32'h2);
    idle();
    tick();

    // Reset with a pending B and a held AR
    i_axi_bready = 1'b0; i_axi_rready = 1'b0;
    set_aw(8'h20); set_w(32'h55AA55AA, 4'hF); set_ar(8'h04);
    tick();
    idle();
    set_ar(8'h08);
    tick();
    check("t6_arready_held", 32'(o_axi_arready), 32'(0));
    check("t6_bvalid_pre", 32'(o_axi_bvalid), 32'(1));
    idle();
    i_reset = 1'b1;
    tick();
    check("t6_bvalid", 32'(o_axi_bvalid), 32'(0));
    check("t6_rvalid", 32'(o_axi_rvalid), 32'(0));
    check("t6_arready", 32'(o_axi_arready), 32'(1));
    check("t6_awready", 32'(o_axi_awready), 32'(1));
    check("t6_wready", 32'(o_axi_wready), 32'(1));
    i_reset = 1'b0;
    i_axi_bready = 1'b1; i_axi_rready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_ar(8'(i * 4));
      tick();
      check("t6_rvalid_rd", 32'(o_axi_rvalid), 32'(1));
      check("t6_clear", o_axi_rdata, 32'h0);
    end
    idle();
    tick();

    // Randomized traffic; payloads stay put until their handshake.
    aw_sent = 0; w_sent = 0;
    aw_go = 1'b0; w_go = 1'b0; ar_go = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!i_axi_awvalid || aw_go) begin
        i_axi_awvalid = 1'($urandom_range(0, 1));
        i_axi_awaddr  = rand_addr();
        i_axi_awprot  = 3'($urandom_range(0, 7));
      end
      if (!i_axi_wvalid || w_go) begin
        i_axi_wvalid = 1'($urandom_range(0, 1));
        i_axi_wdata  = $urandom;
        i_axi_wstrb  = 4'($urandom_range(0, 15));
      end
      if (!i_axi_arvalid || ar_go) begin
        i_axi_arvalid = 1'($urandom_range(0, 1));
        i_axi_araddr  = rand_addr();
        i_axi_arprot  = 3'($urandom_range(0, 7));
      end
      i_axi_bready = ($urandom_range(0, 3) != 0);
      i_axi_rready = ($urandom_range(0, 3) != 0);
      aw_go = i_axi_awvalid && o_axi_awready;
      w_go  = i_axi_wvalid && o_axi_wready;
      ar_go = i_axi_arvalid && o_axi_arready;
      tick();
      if (aw_go) aw_sent++;
      if (w_go)  w_sent++;
    end

    // Drain: pair any unmatched AW/W and let every response out.
    for (int c = 0; c < 60; c++) begin
      if (!i_axi_awvalid || aw_go) begin
        i_axi_awvalid = (aw_sent < w_sent);
        i_axi_awaddr  = rand_addr();
      end
      if (!i_axi_wvalid || w_go) begin
        i_axi_wvalid = (w_sent < aw_sent);
        i_axi_wdata  = $urandom;
        i_axi_wstrb  = 4'hF;
      end
      if (!i_axi_arvalid || ar_go) i_axi_arvalid = 1'b0;
      i_axi_bready = 1'b1;
      i_axi_rready = 1'b1;
      aw_go = i_axi_awvalid && o_axi_awready;
      w_go  = i_axi_wvalid && o_axi_wready;
      ar_go = i_axi_arvalid && o_axi_arready;
      tick();
      if (aw_go) aw_sent++;
      if (w_go)  w_sent++;
    end
    check("drain_aw", 32'(awq.size()), 32'(0));
    check("drain_w",  32'(wdq.size()), 32'(0));
    check("drain_ar", 32'(arq.size()), 32'(0));
    check("drain_bvalid", 32'(o_axi_bvalid), 32'(0));
    check("drain_rvalid", 32'(o_axi_rvalid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
AXI4-Lite slave register file, the endpoint consumer that the AXI4-Lite slave/master property checkers bind to.
- Holds NREGS 32-bit registers.
- Accepts write address and write data independently, each with a one-entry holding buffer.
- Applies byte strobes and returns OKAY/SLVERR responses.
- Supports back-to-back, full-throughput traffic on both read and write paths.

Parameters:
C_AXI_DATA_WIDTH, 32, data width; fixed at 32.
C_AXI_ADDR_WIDTH, 8, byte address width; word index = addr[AW-1:2].
NREGS, 16, number of implemented registers; 1 <= NREGS <= 2^(AW-2).

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_axi_awvalid  input  1  write address valid
o_axi_awready  output  1  write address ready
i_axi_awaddr  input  AW  write byte address
i_axi_awprot  input  3  ignored
i_axi_wvalid  input  1  write data valid
o_axi_wready  output  1  write data ready
i_axi_wdata  input  32  write data
i_axi_wstrb  input  4  byte enables
o_axi_bvalid  output  1  write response valid
i_axi_bready  input  1  write response ready
o_axi_bresp  output  2  write response
i_axi_arvalid  input  1  read address valid
o_axi_arready  output  1  read address ready
i_axi_araddr  input  AW  read byte address
i_axi_arprot  input  3  ignored
o_axi_rvalid  output  1  read data valid
i_axi_rready  input  1  read data ready
o_axi_rdata  output  32  read data
o_axi_rresp  output  2  read response

Behaviour:
Reset (synchronous, i_reset=1):
- All registers are 0.
- awready, wready and arready are 1.
- bvalid and rvalid are 0; bresp, rresp and rdata are 0.
- Held AW/W/AR entries are discarded, including mid-transaction: outstanding responses are dropped.

Write channel holding buffers:
- aw_held is set on an AW handshake that does not fire a write in the same cycle. o_axi_awready = !aw_held (registered).
- W is identical, using w_held and o_axi_wready = !w_held.

Write fire: requires all of the following in one cycle:
- An address is available: aw_held, or an AW handshake this cycle.
- Data is available: w_held, or a W handshake this cycle.
- The B channel is free: !bvalid || bready.

On fire:
- Index idx = addr[AW-1:2]. If idx < NREGS, each byte i with wstrb[i]=1 is updated; bresp=OKAY (00). Otherwise no register changes and bresp=SLVERR (10).
- bvalid rises the next cycle.
- The consumed held flags clear.
- AW and W arriving in the same cycle with B free fire immediately, with no holding.

Write ordering and stalls:
- AW may lead W, or W lead AW, by any number of cycles. Only one of each is held, so the ready of the leading channel drops until its partner arrives.
- bvalid stays high with bresp stable until bready.
- Write latency: 1 cycle from the completing handshake to bvalid.

Read path:
- One-entry AR holding buffer: ar_held, with o_axi_arready = !ar_held (registered).
- A read fires when an address is available (held, or handshaking this cycle) and the R channel is free (!rvalid || rready).
- On fire, on the next cycle: rvalid=1; rdata = reg[idx] with rresp=OKAY if idx < NREGS, otherwise rdata=0 with rresp=SLVERR.
- rdata and rresp are stable while rvalid && !rready.

Read/write interaction:
- A read and a write to the same register firing in the same cycle: the read returns the pre-write value.
- Read and write paths are otherwise independent.

Throughput and protocol:
- With bready=1 and rready=1 held continuously, one write and one read complete per cycle.
- No combinational path from any input to any ready or valid output.
- Responses never exceed accepted requests, so outstanding count per channel is <= 2 (held entry + response). Checker F_LGDEPTH >= 2 suffices.

Test Plan:
- Reset, then AW+W same cycle (addr 0x04, data 0xDEADBEEF, strb 0xF), bready=1 -> bvalid next cycle, bresp=00; read 0x04 -> rvalid 1 cycle after AR, rdata=0xDEADBEEF, rresp=00.
- W (data 0x11223344, strb 0x5) 3 cycles before AW (addr 0x08) -> wready low cycles 1–3, write fires on AW handshake; read 0x08 -> 0x00220044.
- Write then read addr 0x40 (idx 16 = NREGS) -> bresp=10, rresp=10, rdata=0, no register changed.
- bready=0 for 5 cycles with 3 writes issued -> first B stable with bvalid high, one AW and one W held, awready=wready=0; bready=1 -> remaining writes drain one per cycle.
- Read and write to 0x0C (old 0x1, new 0x2) in the same cycle -> rdata=0x1; subsequent read -> 0x2.
- Assert i_reset with bvalid=1 and ar_held=1 -> next cycle bvalid=rvalid=0, all readies=1, all registers read 0.
